// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator: per-channel period, pause, periodic or one-shot mode.
// Define TICKGEN_PRESCALE_EN to add a shared free-running prescaler that stretches every period by PRESCALE.
module tick_gen_multi #(
    parameter int CHANNELS       = 4,
    parameter int WIDTH          = 27,
    parameter int DEFAULT_PERIOD = 75,
    parameter int PRESCALE       = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] en,
    input  logic [CHANNELS-1:0] oneshot,
    input  logic [CHANNELS-1:0] load,
    input  logic [WIDTH-1:0]    period_in,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] busy
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    state_e              state_q  [CHANNELS];
    state_e              state_d  [CHANNELS];
    logic [WIDTH-1:0]    count_q  [CHANNELS];
    logic [WIDTH-1:0]    count_d  [CHANNELS];
    logic [WIDTH-1:0]    period_q [CHANNELS];
    logic [WIDTH-1:0]    period_d [CHANNELS];
    logic [CHANNELS-1:0] tick_q;
    logic [CHANNELS-1:0] tick_d;
    logic                step;

`ifdef TICKGEN_PRESCALE_EN
    localparam int PS_W = $clog2(PRESCALE);
    logic [PS_W-1:0] ps_q;
    logic [PS_W-1:0] ps_d;

    // Shared across channels and never restarted by load/en, so the first tick after a load has phase jitter.
    always_comb begin
        step = (ps_q == PS_W'(PRESCALE - 1));
        ps_d = step ? '0 : ps_q + PS_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ps_q <= '0;
        else        ps_q <= ps_d;
    end
`else
    logic unused_prescale;
    assign unused_prescale = (PRESCALE >= 2);
    assign step            = 1'b1;
`endif

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i]  = state_q[i];
            count_d[i]  = count_q[i];
            period_d[i] = period_q[i];
            tick_d[i]   = 1'b0;
            if (load[i]) begin
                period_d[i] = (period_in == '0) ? WIDTH'(1) : period_in;
                count_d[i]  = '0;
                state_d[i]  = ST_RUN;
            end else if (state_q[i] == ST_DONE) begin
                count_d[i] = '0;
            end else if (en[i] && step) begin
                if (count_q[i] == period_q[i] - WIDTH'(1)) begin
                    count_d[i] = '0;
                    tick_d[i]  = 1'b1;
                    if (oneshot[i]) state_d[i] = ST_DONE;
                end else begin
                    count_d[i] = count_q[i] + WIDTH'(1);
                end
            end
        end
    end

    // NOTE: the per-channel arrays are small registers, not RAM, so resetting every entry is cheap and required.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= ST_RUN;
                count_q[i]  <= '0;
                period_q[i] <= WIDTH'(DEFAULT_PERIOD);
            end
            tick_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= state_d[i];
                count_q[i]  <= count_d[i];
                period_q[i] <= period_d[i];
            end
            tick_q <= tick_d;
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            busy[i] = (state_q[i] == ST_RUN) && en[i];
        end
    end

    assign tick = tick_q;

endmodule

// File: tb/tb_tick_gen_multi.sv
// Self-checking bench for tick_gen_multi: directed timing cases plus randomized traffic against a step-counting model.
// Build with TICKGEN_PRESCALE_EN defined to exercise the prescaler (PRESCALE = 4, reset period 3).
module tb_tick_gen_multi;

    localparam int CH = 4;
    localparam int W  = 27;
    localparam int PS = 4;
`ifdef TICKGEN_PRESCALE_EN
    localparam int DEFP = 3;
`else
    localparam int DEFP = 75;
`endif

    logic          clk;
    logic          rst_n;
    logic [CH-1:0] en;
    logic [CH-1:0] oneshot;
    logic [CH-1:0] load;
    logic [W-1:0]  period_in;
    logic [CH-1:0] tick;
    logic [CH-1:0] busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;

    tick_gen_multi #(
        .CHANNELS(CH), .WIDTH(W), .DEFAULT_PERIOD(DEFP), .PRESCALE(PS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .oneshot(oneshot), .load(load),
        .period_in(period_in), .tick(tick), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: each channel counts enabled steps since its last start and ticks when that reaches its period.
    int unsigned m_per  [CH];
    int unsigned m_steps[CH];
    bit          m_done [CH];
    bit          m_tick [CH];
    int unsigned m_cycles;

    always @(posedge clk) begin
        bit m_step;
        if (!rst_n) begin
            m_cycles = 0;
            for (int i = 0; i < CH; i++) begin
                m_per[i] = DEFP; m_steps[i] = 0; m_done[i] = 0; m_tick[i] = 0;
            end
        end else begin
`ifdef TICKGEN_PRESCALE_EN
            m_step = ((m_cycles % PS) == PS - 1);
`else
            m_step = 1;
`endif
            m_cycles++;
            for (int i = 0; i < CH; i++) begin
                m_tick[i] = 0;
                if (load[i]) begin
                    m_per[i]   = (period_in == 0) ? 1 : int'(period_in);
                    m_steps[i] = 0;
                    m_done[i]  = 0;
                end else if (!m_done[i] && en[i] && m_step) begin
                    m_steps[i]++;
                    if (m_steps[i] == m_per[i]) begin
                        m_steps[i] = 0;
                        m_tick[i]  = 1;
                        m_done[i]  = oneshot[i];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [CH-1:0] exp_tick;
        logic [CH-1:0] exp_busy;
        if (cmp_en) begin
            for (int i = 0; i < CH; i++) begin
                exp_tick[i] = m_tick[i];
                exp_busy[i] = !m_done[i] && en[i];
            end
            check("model_tick", tick, exp_tick);
            check("model_busy", busy, exp_busy);
        end
    end

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns the number of edges until tick[ch] is seen high; a timeout counts as a failure.
    task automatic wait_tick(input int ch, input int budget, output int n);
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (!tick[ch] && n < budget);
        if (!tick[ch]) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_tick ch%0d: no tick within %0d cycles", ch, budget);
        end
    endtask

    initial begin
        int n;
        int cnt;
        rst_n = 1'b0; en = '0; oneshot = '0; load = '0; period_in = '0;
        cyc(1);
        cmp_en = 1;
        cyc(1);
        check("reset_tick", tick, 4'b0000);
        check("reset_busy", busy, 4'b0000);

`ifdef TICKGEN_PRESCALE_EN
        en = 4'b0001;
        rst_n = 1'b1;
        wait_tick(0, 40, n);
        check("ps_first_in_9_12", (n >= 9 && n <= 12), 1);
        wait_tick(0, 40, n);
        check("ps_period_a", n, 12);
        wait_tick(0, 40, n);
        check("ps_period_b", n, 12);
`else
        en = 4'b0001;
        #1;
        check("busy_eq_en_in_reset", busy, 4'b0001);
        rst_n = 1'b1;
        wait_tick(0, 200, n);
        check("ch0_first_75", n, 75);
        wait_tick(0, 200, n);
        check("ch0_second_150", n, 75);
        wait_tick(0, 200, n);
        check("ch0_third_225", n, 75);

        // One-shot on ch1, fired twice.
        for (int rep = 0; rep < 2; rep++) begin
            load[1] = 1'b1; period_in = 10; oneshot[1] = 1'b1; en[1] = 1'b1;
            cyc(1);
            load[1] = 1'b0;
            wait_tick(1, 50, n);
            check("ch1_oneshot_10", n, 10);
            cyc(1);
            check("ch1_busy_done", busy[1], 0);
            cnt = 0;
            for (int i = 0; i < 50; i++) begin
                cyc(1);
                if (tick[1]) cnt++;
            end
            check("ch1_no_more_ticks", cnt, 0);
        end

        // Pause ch2 for 3 cycles in a period of 4.
        load[2] = 1'b1; period_in = 4; en[2] = 1'b1;
        cyc(1);
        load[2] = 1'b0;
        cyc(2);
        en[2] = 1'b0;
        cyc(3);
        en[2] = 1'b1;
        wait_tick(2, 20, n);
        check("ch2_pause_total_7", n + 5, 7);

        // Reload to a shorter period mid-count.
        load[2] = 1'b1; period_in = 8;
        cyc(1);
        load[2] = 1'b0;
        cyc(2);
        load[2] = 1'b1; period_in = 3;
        cyc(1);
        load[2] = 1'b0;
        wait_tick(2, 20, n);
        check("ch2_reload_3", n, 3);

        // Zero period clamps to 1: tick every cycle.
        load[3] = 1'b1; period_in = 0; en[3] = 1'b1;
        cyc(1);
        load[3] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("ch3_period1_tick", tick[3], 1);
        end

        // Reset one edge before ch0 would tick.
        rst_n = 1'b0; en = 4'b0001; oneshot = '0;
        cyc(1);
        rst_n = 1'b1;
        cyc(74);
        rst_n = 1'b0;
        cyc(1);
        check("no_tick_on_reset_edge", tick[0], 0);
        rst_n = 1'b1;
        wait_tick(0, 200, n);
        check("ch0_after_reset_75", n, 75);
`endif

        // Randomized traffic, checked every cycle by the model compare.
        for (int i = 0; i < 3000; i++) begin
            en        = CH'($urandom_range(0, 15) | (($urandom_range(0, 3) == 0) ? 0 : 15));
            load      = ($urandom_range(0, 9) == 0) ? CH'($urandom) : '0;
            period_in = W'($urandom_range(0, 12));
            if ($urandom_range(0, 19) == 0) oneshot = CH'($urandom);
            cyc(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tick_gen_multi.md
# tick_gen_multi

Multi-channel, runtime-programmable tick generator for the Whack-a-mole game logic. It replaces the fixed-modulus single tick counter with CHANNELS independent counters. Each counter has a loadable period, pause/enable, and a periodic or one-shot mode. Channels drive mole pop-up timing, the whack window, the random-number sampling strobe and the game-over timer. An optional shared prescaler stretches periods without widening the counters.

## Interface
- `CHANNELS`, default 4: number of independent tick channels (1..16).
- `WIDTH`, default 27: counter and period width in bits. 2^27 > 100 M covers 1 s at 100 MHz.
- `DEFAULT_PERIOD`, default 75: period loaded by reset. Range 1..2^WIDTH-1.
- `PRESCALE`, default 1000: prescaler modulus. Used only when `TICKGEN_PRESCALE_EN` is defined. Must be ≥ 2.
- `clk` in 1: system clock, 100 MHz.
- `rst_n` in 1: synchronous, active-low reset.
- `en` in CHANNELS: per-channel count enable. Low means pause; the count is held.
- `oneshot` in CHANNELS: per-channel mode. 1 = one-shot, 0 = periodic.
- `load` in CHANNELS: per-channel load strobe. Writes `period_in` and restarts the channel.
- `period_in` in WIDTH: shared period value, sampled by any channel whose `load` bit is high.
- `tick` out CHANNELS: registered single-cycle tick pulse per channel.
- `busy` out CHANNELS: channel is in RUN state and `en` is high. Combinational from the state register and `en`.

## Operation
- Per-channel state:
  - `period_q[WIDTH]`
  - `count[WIDTH]`
  - 1-bit FSM with states RUN and DONE
  - `tick` register
- Step pulse:
  - Without prescaler: `step` = 1 every cycle.
  - With prescaler: `step` = 1 when the prescaler equals PRESCALE-1.
- Per-channel priority per clock edge:
  1. `rst_n` = 0: `count` = 0, `period_q` = DEFAULT_PERIOD, state RUN, `tick` = 0.
  2. `load` = 1: `period_q` = `period_in`. A value of 0 is clamped to 1. `count` = 0, state RUN, `tick` = 0. `en` and `step` are ignored this cycle.
  3. State DONE: `count` held at 0, `tick` = 0. Only `load` or reset leaves DONE.
  4. RUN, `en` = 1, `step` = 1:
     - If `count` == `period_q`-1: `count` = 0 and `tick` = 1. If `oneshot` = 1, state goes to DONE.
     - Otherwise `count` + 1 and `tick` = 0.
  5. Any other case: `count` holds and `tick` = 0.
- `oneshot` is sampled only at the terminal step. Changing it mid-count has no effect until then.
- Period 1 without prescaler and `en` held high: `tick` stays high every cycle. This is legal and intended.
- All comparisons are unsigned at WIDTH bits. `count` never exceeds `period_q`-1.
- Loading a period smaller than the current `count` is safe, because load zeroes `count`.
- Channels are fully independent. Simultaneous `load`s on several channels all take the same `period_in`.

## Timing
- Reset values:
  - `tick` = 0 on all channels.
  - `busy` = `en`, since state is RUN after reset.
  - Prescaler counter = 0.
- Latency without prescaler:
  - Starting from `count` = 0 with `en` high for edges 1..P, `tick` is high in the cycle after edge P, for exactly one cycle.
  - With P ≥ 2 and `en` held, the tick period is P cycles.
- Pausing: deasserting `en` for k cycles delays the next tick by exactly k cycles.
- `load` takes effect at the same edge it is sampled. The following tick arrives P cycles after the load edge, with `en` high.
- Reset mid-count aborts the count. No `tick` is produced on the reset edge.
- Prescaler behaviour:
  - The prescaler is free-running and shared. It is not reset by `load` or `en`.
  - The first tick after load/enable therefore arrives between (P-1)·PRESCALE+1 and P·PRESCALE cycles later. Later ticks are exactly P·PRESCALE apart.

## Configuration
- `TICKGEN_PRESCALE_EN` defined:
  - A `$clog2(PRESCALE)`-bit free-running prescaler generates `step`.
  - The effective period is `period_q`·PRESCALE clock cycles.
- Not defined:
  - No prescaler logic; `step` is tied to 1 and `PRESCALE` is unused.
  - The effective period is `period_q` cycles.

## Test plan
- Reset, then `en[0]` = 1, periodic, no prescaler, DEFAULT_PERIOD = 75 → `tick[0]` high for one cycle at cycles 75, 150, 225 after `en` rise; the other `tick` bits stay 0.
- `load[1]` with `period_in` = 10, `oneshot[1]` = 1, `en[1]` = 1 → one `tick[1]` 10 cycles after load, then `busy[1]` = 0 and no further ticks for 50 cycles; a second `load` gives a tick 10 cycles later.
- Period 4, `en[2]` dropped for 3 cycles mid-count → the tick arrives at cycle 7 instead of 4. Reload to 3 while `count` = 2 under period 8 → the tick arrives 3 cycles after the load.
- `period_in` = 0 loaded on ch3 → behaves as period 1: `tick[3]` high every cycle while `en[3]` = 1.
- `rst_n` pulled low for one cycle while ch0 is at `count` = 74 of 75 → no tick on the reset edge; the next tick comes 75 cycles after reset release.
- With `TICKGEN_PRESCALE_EN`, PRESCALE = 4, period 3, `en` held from reset → ticks exactly 12 cycles apart; the first lands within 9..12 cycles.
